// File: rtl/instr_packer.sv
//------------------------------------------------------------------------------
// instr_packer: packs decoded instruction fields into 32-bit words and writes
// them sequentially into program memory through a 2-entry skid buffer.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module instr_packer #(
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_imb,
   input  logic [3:0]        in_ra,
   input  logic [3:0]        in_rb,
   input  logic [13:0]       in_imm,
   input  logic [4:0]        in_opc,
   input  logic [3:0]        in_rc,
   input  logic [2:0]        in_cond,
   input  logic              in_cmp,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_stall,
   output logic              busy,
   output logic              full,
   output logic [ADDR_W:0]   count
);

   localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W+1:0] DEPTH_X = (ADDR_W+2)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      FULL = 2'd2
   } state_t;

   state_t              state_q,      state_d;
   logic                out_valid_q,  out_valid_d;
   logic [31:0]         out_data_q,   out_data_d;
   logic                skid_valid_q, skid_valid_d;
   logic [31:0]         skid_data_q,  skid_data_d;
   logic [ADDR_W-1:0]   addr_q,       addr_d;
   logic [ADDR_W:0]     count_q,      count_d;

   logic [1:0]          occ;
   logic [ADDR_W+1:0]   fill;
   logic [31:0]         word_in;
   logic                push;
   logic                done;

   // Register form zeroes [22:13] so stale immediates never leak into the word.
   always_comb begin
      word_in        = 32'd0;
      word_in[31]    = in_imb;
      word_in[30:27] = in_ra;
      if (in_imb) begin
         word_in[26:13] = in_imm;
      end else begin
         word_in[26:23] = in_rb;
      end
      word_in[12:8]  = in_opc;
      word_in[7:4]   = in_rc;
      word_in[3:1]   = in_cond;
      word_in[0]     = in_cmp;
   end

   assign occ      = {1'b0, out_valid_q} + {1'b0, skid_valid_q};
   assign fill     = {1'b0, count_q} + {{ADDR_W{1'b0}}, occ};
   assign in_ready = (state_q == LOAD) && (occ < 2'd2) && (fill < DEPTH_X);
   assign push     = in_valid && in_ready;
   assign done     = out_valid_q && !mem_stall;

   always_comb begin
      state_d      = state_q;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      addr_d       = addr_q;
      count_d      = count_q;

      if (start) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
         addr_d       = base_addr;
         count_d      = '0;
         state_d      = LOAD;
      end else begin
         if (done) begin
            addr_d = addr_q + 1'b1;
            if (count_q != DEPTH_C) begin
               count_d = count_q + 1'b1;
            end
            if ((state_q == LOAD) && (count_d == DEPTH_C)) begin
               state_d = FULL;
            end
         end

         // Oldest word lives in the output register; the skid only fills behind it.
         if (done) begin
            if (skid_valid_q) begin
               out_data_d   = skid_data_q;
               skid_valid_d = 1'b0;
            end else begin
               out_valid_d = push;
               if (push) begin
                  out_data_d = word_in;
               end
            end
         end else if (push) begin
            if (!out_valid_q) begin
               out_valid_d = 1'b1;
               out_data_d  = word_in;
            end else begin
               skid_valid_d = 1'b1;
               skid_data_d  = word_in;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         out_valid_q  <= 1'b0;
         out_data_q   <= 32'd0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= 32'd0;
         addr_q       <= '0;
         count_q      <= '0;
      end else begin
         state_q      <= state_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         addr_q       <= addr_d;
         count_q      <= count_d;
      end
   end

   assign mem_we    = out_valid_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = out_data_q;
   assign busy      = (state_q == LOAD) || (occ != 2'd0);
   assign full      = (state_q == FULL);
   assign count     = count_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_packer.sv
//------------------------------------------------------------------------------
// tb_instr_packer: directed bench for instr_packer with a 4-word depth window.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_instr_packer;

   localparam int ADDR_W = 10;
   localparam int DEPTH  = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic              in_valid;
   logic              in_ready;
   logic              in_imb;
   logic [3:0]        in_ra;
   logic [3:0]        in_rb;
   logic [13:0]       in_imm;
   logic [4:0]        in_opc;
   logic [3:0]        in_rc;
   logic [2:0]        in_cond;
   logic              in_cmp;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              mem_stall;
   logic              busy;
   logic              full;
   logic [ADDR_W:0]   count;

   int total = 0;
   int bad   = 0;

   logic [ADDR_W-1:0] exp_addr [4];
   logic [31:0]       exp_data [4];

   instr_packer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_imb    (in_imb),
      .in_ra     (in_ra),
      .in_rb     (in_rb),
      .in_imm    (in_imm),
      .in_opc    (in_opc),
      .in_rc     (in_rc),
      .in_cond   (in_cond),
      .in_cmp    (in_cmp),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_stall (mem_stall),
      .busy      (busy),
      .full      (full),
      .count     (count)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Register-form word carrying only rc, so the packed value is rc<<4.
   task automatic simple_fields(input logic [3:0] rc);
      in_imb  = 1'b0;
      in_ra   = 4'd0;
      in_rb   = 4'd0;
      in_imm  = 14'h3FFF;
      in_opc  = 5'd0;
      in_rc   = rc;
      in_cond = 3'd0;
      in_cmp  = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"},  {31'd0, in_ready},  32'd0);
      check({tag, "_mem_we"},    {31'd0, mem_we},    32'd0);
      check({tag, "_mem_addr"},  {22'd0, mem_addr},  32'd0);
      check({tag, "_mem_wdata"}, mem_wdata,          32'd0);
      check({tag, "_busy"},      {31'd0, busy},      32'd0);
      check({tag, "_full"},      {31'd0, full},      32'd0);
      check({tag, "_count"},     {21'd0, count},     32'd0);
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      base_addr = '0;
      in_valid  = 1'b0;
      mem_stall = 1'b0;
      simple_fields(4'd0);
      step();
      step();
      check_reset_outputs("reset");
      rst = 1'b0;
      step();
      check("idle_in_ready", {31'd0, in_ready}, 32'd0);

      // Immediate form
      start = 1'b1; base_addr = 10'h010;
      step();
      start = 1'b0;
      check("t1_in_ready", {31'd0, in_ready}, 32'd1);
      check("t1_busy",     {31'd0, busy},     32'd1);
      in_valid = 1'b1;
      in_imb = 1'b1; in_ra = 4'd3; in_rb = 4'd0; in_imm = 14'h1234;
      in_opc = 5'd5; in_rc = 4'd2; in_cond = 3'd1; in_cmp = 1'b1;
      step();
      in_valid = 1'b0;
      check("t1_mem_we",    {31'd0, mem_we},   32'd1);
      check("t1_mem_addr",  {22'd0, mem_addr}, 32'h010);
      check("t1_mem_wdata", mem_wdata,         32'h9A468523);
      step();
      check("t1_count",     {21'd0, count},    32'd1);
      check("t1_we_drop",   {31'd0, mem_we},   32'd0);

      // Register form; imm must be ignored
      in_valid = 1'b1;
      in_imb = 1'b0; in_ra = 4'd1; in_rb = 4'd2; in_imm = 14'h3FFF;
      in_opc = 5'h1F; in_rc = 4'hF; in_cond = 3'd7; in_cmp = 1'b0;
      step();
      in_valid = 1'b0;
      check("t2_mem_wdata", mem_wdata,         32'h09001FFE);
      check("t2_mem_addr",  {22'd0, mem_addr}, 32'h011);
      step();
      check("t2_count",     {21'd0, count},    32'd2);

      // Stall fills both slots, then drains in order
      start = 1'b1; base_addr = 10'h100;
      step();
      start = 1'b0;
      mem_stall = 1'b1;
      in_valid  = 1'b1;
      simple_fields(4'd1);
      step();
      simple_fields(4'd2);
      step();
      simple_fields(4'd3);
      check("t3_ready_full", {31'd0, in_ready}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         check("t3_stall_we",    {31'd0, mem_we},   32'd1);
         check("t3_stall_wdata", mem_wdata,         32'h10);
         check("t3_stall_addr",  {22'd0, mem_addr}, 32'h100);
         step();
      end
      in_valid  = 1'b0;
      mem_stall = 1'b0;
      step();
      check("t3_second_we",    {31'd0, mem_we},   32'd1);
      check("t3_second_wdata", mem_wdata,         32'h20);
      check("t3_second_addr",  {22'd0, mem_addr}, 32'h101);
      check("t3_count1",       {21'd0, count},    32'd1);
      step();
      check("t3_drained_we",   {31'd0, mem_we},   32'd0);
      check("t3_count2",       {21'd0, count},    32'd2);
      check("t3_final_addr",   {22'd0, mem_addr}, 32'h102);

      // Depth limit with address wrap
      exp_addr[0] = 10'h3FE; exp_addr[1] = 10'h3FF; exp_addr[2] = 10'h000; exp_addr[3] = 10'h001;
      exp_data[0] = 32'h10;  exp_data[1] = 32'h20;  exp_data[2] = 32'h30;  exp_data[3] = 32'h40;
      start = 1'b1; base_addr = 10'h3FE;
      step();
      start    = 1'b0;
      in_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         simple_fields(4'(k + 1));
         step();
         check("t4_we",    {31'd0, mem_we},   32'd1);
         check("t4_addr",  {22'd0, mem_addr}, {22'd0, exp_addr[k]});
         check("t4_wdata", mem_wdata,         exp_data[k]);
      end
      check("t4_ready_at_limit", {31'd0, in_ready}, 32'd0);
      simple_fields(4'd5);
      step();
      check("t4_full",     {31'd0, full},     32'd1);
      check("t4_count",    {21'd0, count},    32'd4);
      check("t4_we_off",   {31'd0, mem_we},   32'd0);
      check("t4_in_ready", {31'd0, in_ready}, 32'd0);
      check("t4_busy",     {31'd0, busy},     32'd0);
      simple_fields(4'd6);
      step();
      in_valid = 1'b0;
      check("t4_no_extra_we", {31'd0, mem_we},   32'd0);
      check("t4_count_sat",   {21'd0, count},    32'd4);
      check("t4_addr_end",    {22'd0, mem_addr}, 32'h002);

      // start flushes pending words
      start = 1'b1; base_addr = 10'h200;
      step();
      start = 1'b0;
      check("t5_full_cleared", {31'd0, full}, 32'd0);
      mem_stall = 1'b1;
      in_valid  = 1'b1;
      simple_fields(4'd7);
      step();
      simple_fields(4'd8);
      step();
      in_valid = 1'b0;
      check("t5_pending_we", {31'd0, mem_we},   32'd1);
      check("t5_pending_rd", {31'd0, in_ready}, 32'd0);
      start = 1'b1; base_addr = 10'h280;
      step();
      start = 1'b0;
      check("t5_flush_we",   {31'd0, mem_we},   32'd0);
      check("t5_flush_cnt",  {21'd0, count},    32'd0);
      check("t5_flush_addr", {22'd0, mem_addr}, 32'h280);
      check("t5_flush_busy", {31'd0, busy},     32'd1);
      mem_stall = 1'b0;
      step();
      check("t5_dropped_we", {31'd0, mem_we},   32'd0);
      check("t5_addr_hold",  {22'd0, mem_addr}, 32'h280);

      // Reset mid-LOAD with a word pending
      mem_stall = 1'b1;
      in_valid  = 1'b1;
      simple_fields(4'd9);
      step();
      in_valid = 1'b0;
      check("t5_pre_rst_we", {31'd0, mem_we}, 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      mem_stall = 1'b0;
      check_reset_outputs("t5_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
